// File: rtl/kw_encode_iter.sv
// kw_encode_iter: drains a multi-hot vector as a stream of bit indices,
// one index per output beat, with o_last marking the final index.
// Default order is lowest index first. Define KW_ENCODE_ITER_MSB_FIRST_EN
// to emit the highest index first instead.
// I_WIDTH must be >= 2 and O_WIDTH must be >= $clog2(I_WIDTH).
module kw_encode_iter #(
  parameter int I_WIDTH = 8,
  parameter int O_WIDTH = $clog2(I_WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_v,
  output logic               i_r,
  input  logic [I_WIDTH-1:0] i,
  output logic               o_v,
  input  logic               o_r,
  output logic [O_WIDTH-1:0] o,
  output logic               o_last
);

  logic [I_WIDTH-1:0] pend;
  logic [I_WIDTH-1:0] sel_mask;
  logic [O_WIDTH-1:0] sel_idx;
  logic               busy;
  logic               one_left;
  logic               in_fire;
  logic               out_fire;

  // Select the bit to emit next; index stays 0 when nothing is pending.
  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
`ifdef KW_ENCODE_ITER_MSB_FIRST_EN
    // Ascending scan: the last hit is the highest set bit.
    for (int k = 0; k < I_WIDTH; k++) begin
      if (pend[k]) begin
        sel_idx  = O_WIDTH'(k);
        sel_mask = I_WIDTH'(1) << k;
      end
    end
`else
    // Descending scan: the last hit is the lowest set bit.
    for (int k = I_WIDTH - 1; k >= 0; k--) begin
      if (pend[k]) begin
        sel_idx  = O_WIDTH'(k);
        sel_mask = I_WIDTH'(1) << k;
      end
    end
`endif
  end

  assign busy     = (pend != '0);
  // Exactly one bit set: clearing the lowest set bit leaves nothing.
  assign one_left = busy && ((pend & (pend - I_WIDTH'(1))) == '0);
  assign out_fire = busy && o_r;
  // Accept a new vector while idle or in the same cycle the final beat leaves.
  assign i_r      = !busy || (out_fire && one_left);
  assign in_fire  = i_v && i_r;

  assign o_v    = busy;
  assign o      = sel_idx;
  assign o_last = one_left;

  // Pending mask: a new vector overwrites (and wins over the final-beat clear),
  // otherwise an accepted beat retires its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (in_fire) begin
      pend <= i;
    end else if (out_fire) begin
      pend <= pend & ~sel_mask;
    end
  end

endmodule

// File: tb/tb_kw_encode_iter.sv
// Bench for kw_encode_iter (I_WIDTH=8): directed scenarios followed by random
// traffic, all compared against a queue-of-indices reference model.
module tb_kw_encode_iter;

  localparam int IW = 8;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_v = 1'b0;
  logic          i_r;
  logic [IW-1:0] i = '0;
  logic          o_v;
  logic          o_r = 1'b0;
  logic [OW-1:0] o;
  logic          o_last;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int got_q[$];
  int ref_q[$];

  kw_encode_iter #(.I_WIDTH(IW), .O_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .i_v(i_v), .i_r(i_r), .i(i),
    .o_v(o_v), .o_r(o_r), .o(o), .o_last(o_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected beat list for a vector: set bit positions in emission order.
  function automatic void indices_of(input logic [IW-1:0] v, output int q[$]);
    q = {};
    for (int k = 0; k < IW; k++) begin
      if (v[k]) begin
`ifdef KW_ENCODE_ITER_MSB_FIRST_EN
        q.push_front(k);
`else
        q.push_back(k);
`endif
      end
    end
  endfunction

  // One clock cycle: drive, check against model, advance model at the edge.
  task automatic cycle(input logic iv, input logic [IW-1:0] d, input logic orr);
    logic exp_ir;
    logic fire_in;
    logic fire_out;
    int   nq[$];
    i_v = iv;
    i   = d;
    o_r = orr;
    #1;
    exp_ir = (exp_q.size() == 0) || (orr && exp_q.size() == 1);
    check("o_v", o_v, exp_q.size() != 0);
    check("o", o, (exp_q.size() != 0) ? exp_q[0] : 0);
    check("o_last", o_last, exp_q.size() == 1);
    check("i_r", i_r, exp_ir);
    if (o_v && orr) got_q.push_back(int'(o));
    fire_in  = iv && exp_ir;
    fire_out = (exp_q.size() != 0) && orr;
    @(posedge clk);
    if (fire_in) begin
      indices_of(d, nq);
      exp_q = nq;
    end else if (fire_out) begin
      void'(exp_q.pop_front());
    end
    #1;
  endtask

  task automatic check_got(input string tag);
    check({tag, "_count"}, got_q.size(), ref_q.size());
    for (int k = 0; k < ref_q.size() && k < got_q.size(); k++)
      check({tag, "_beat"}, got_q[k], ref_q[k]);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_o_v", o_v, 0);
    check("rst_o", o, 0);
    check("rst_o_last", o_last, 0);
    check("rst_i_r", i_r, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single vector
    got_q = {};
`ifdef KW_ENCODE_ITER_MSB_FIRST_EN
    ref_q = {7, 4, 2};
`else
    ref_q = {2, 4, 7};
`endif
    cycle(1'b1, 8'b1001_0100, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1);
    check_got("single");

    // Backpressure
    got_q = {};
`ifdef KW_ENCODE_ITER_MSB_FIRST_EN
    ref_q = {1, 0};
`else
    ref_q = {0, 1};
`endif
    cycle(1'b1, 8'h03, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'hA5, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);
    check_got("bp");

    // Back-to-back with zero vector in between
    got_q = {};
    ref_q = {0, 7};
    cycle(1'b1, 8'h01, 1'b1);
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b1, 8'h80, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check_got("b2b");

    // Full vector
    got_q = {};
    ref_q = {};
    for (int k = 0; k < IW; k++) begin
`ifdef KW_ENCODE_ITER_MSB_FIRST_EN
      ref_q.push_back(IW - 1 - k);
`else
      ref_q.push_back(k);
`endif
    end
    cycle(1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < IW + 2; k++) cycle(1'b0, '0, 1'b1);
    check_got("full");

    // Reset mid-stream
    cycle(1'b1, 8'b1010_0000, 1'b0);
    cycle(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_o_v", o_v, 0);
    check("midrst_o", o, 0);
    check("midrst_o_last", o_last, 0);
    check("midrst_i_r", i_r, 1);
    exp_q = {};
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q = {};
    ref_q = {};
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);
    check_got("stale");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic          rv;
      logic [IW-1:0] rd;
      logic          rr;
      rv = ($urandom_range(0, 2) != 0);
      rd = IW'($urandom);
      if ($urandom_range(0, 7) == 0) rd = '0;
      rr = ($urandom_range(0, 3) != 0);
      cycle(rv, rd, rr);
    end
    for (int k = 0; k < IW + 2; k++) cycle(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kw_encode_iter.md
# kw_encode_iter

Sequential encoder: accepts a multi-hot bit vector through a valid/ready handshake and emits the index of each set bit as one binary-index beat per cycle, lowest index first, with a last-beat marker. It is the inverse of the team's valid-qualified one-hot decoder: a decoder turns index + valid into a bit mask, and this block turns a mask back into a stream of indices. Typical uses are draining pending-request masks, sparse-bitmap walkers and completion-vector processing.

## Interface
- I_WIDTH, default 8: input vector width; must be ≥ 2.
- O_WIDTH, default $clog2(I_WIDTH): index width; must be ≥ $clog2(I_WIDTH).

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_v  input  1  input vector valid.
- i_r  output  1  input ready.
- i  input  I_WIDTH  bit vector to encode.
- o_v  output  1  output index valid.
- o_r  input  1  output ready.
- o  output  O_WIDTH  index of the current set bit; 0 when o_v=0.
- o_last  output  1  high with o_v on the final index of the current vector.

## Operation
- State: pending register `pend[I_WIDTH-1:0]`. Busy means pend≠0.
- Input handshake: a transfer happens when i_v && i_r. i_r = !busy || (o_v && o_r && o_last).
- On input transfer: pend ← i. This is a full overwrite. In the back-to-back case, the final-beat clear and the load happen in the same cycle, and the load wins.
- Output: o_v = busy. o = index of the lowest set bit of pend. o_last = pend has exactly one bit set.
- Output transfer (o_v && o_r): clear that bit in pend. No transfer: pend holds, and o and o_last are stable.
- Zero vector: accepted normally (i_r as above), produces no beats, and leaves the block idle. It is consumed in one cycle.
- The input vector is not re-sampled while busy. Changes on i while i_r=0 are ignored.
- Indices are zero-extended to O_WIDTH.

## Timing
- Reset (async assert, sync deassert handled upstream): pend=0, so o_v=0, o=0, o_last=0, i_r=1.
- Reset mid-stream discards all pending indices immediately. No partial beats survive.
- Latency: vector accepted at edge N → first index valid in the cycle after edge N.
- Throughput: one index per cycle while o_r=1. A vector with k set bits occupies the block for k cycles.
- Back-to-back vectors: with o_r held high, the next vector's first beat immediately follows the previous o_last beat, with no bubble.
- o_v, o and o_last are functions of registered state only. There is no combinational path from i or i_v to the outputs.
- i_r depends combinationally on o_r. Downstream must not make o_r depend on i_r.
- All-ones vector: I_WIDTH beats with indices 0..I_WIDTH-1, and o_last on index I_WIDTH-1.

## Configuration
- KW_ENCODE_ITER_MSB_FIRST_EN defined: priority reverses. o is the highest set bit, and the beat order is descending. o_last is unchanged (single bit remaining).
- Not defined: lowest index first, as described above.

## Test plan
- Reset: assert rst_n=0 mid-stream with pend=8'b1010_0000 → o_v=0, o=0, o_last=0, i_r=1 immediately. After release, no stale beats are emitted.
- Single vector: I_WIDTH=8, i=8'b1001_0100, o_r=1 → beats o=2, 4, 7 on consecutive cycles, o_last only on 7, i_r=0 during the first two beats.
- Backpressure: i=8'b0000_0011, o_r=0 for 3 cycles → o=0 is held stable with o_v=1 and o_last=0. Then o_r=1 → o=0, then o=1 with o_last=1.
- Back-to-back and zero vector: i=8'h01, then i=8'h00, then i=8'h80 with i_v held high and o_r=1 →
  - beat o=0 (last) is emitted;
  - the zero vector is accepted with no beat;
  - beat o=7 (last) follows;
  - i_r is high at every accept point.
- Full vector: i=8'hFF → 8 consecutive beats o=0..7, o_last on 7, then idle with i_r=1.
- MSB-first build (macro defined): i=8'b1001_0100 → beats o=7, 4, 2, with o_last on 2.
